// File: rtl/vending_pkg.sv
// Shared coin encoding and acceptor state encoding for the vending front end.
// The vending FSM decodes coins with the same constants.
package vending_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        BURST   = 2'd2
    } acc_state_e;

    // Running transaction value in 5 rs units, clamped at 15.
    function automatic logic [3:0] sat_add4(input logic [3:0] a, input logic [1:0] b);
        logic [4:0] s;
        s = {1'b0, a} + {3'b000, b};
        return s[4] ? 4'hF : s[3:0];
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] a);
        return (a == 16'hFFFF) ? a : a + 16'd1;
    endfunction

endpackage

// File: rtl/coin_debounce.sv
// One coin sensor: 2-flop synchroniser, stability counter and a single-cycle
// event on the rising edge of the qualified level.
module coin_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic coin_event
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic          synced;
    logic [CW-1:0] cnt;
    logic          qual;
    logic          hit;

    assign synced = sync[1];
    // The counter reaches DEBOUNCE_CYCLES on the same edge the level qualifies,
    // so the event is flagged one cycle earlier and takes effect on that edge.
    assign hit        = synced && (cnt == CNT_LAST);
    assign coin_event = hit && !qual;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= 2'b00;
            cnt  <= '0;
            qual <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (!synced) begin
                cnt  <= '0;
                qual <= 1'b0;
            end else begin
                if (cnt != CNT_MAX) begin
                    cnt <= cnt + 1'b1;
                end
                if (hit) begin
                    qual <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/coin_acceptor.sv
// Coin front end: debounces both sensors, buffers one transaction and replays it
// to the vending FSM as a gap-free burst. Optional COIN_ACCEPTOR_STATS_EN adds
// saturating totals of accepted coins.
module coin_acceptor
    import vending_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int IDLE_TIMEOUT    = 16,
    parameter int FIFO_DEPTH      = 4,
    parameter int PRICE_UNITS     = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          coin5_raw,
    input  logic                          coin10_raw,
    output logic [1:0]                    coin_code,
    output logic                          burst_active,
    output logic                          coin_reject,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output acc_state_e                    state_dbg
`ifdef COIN_ACCEPTOR_STATS_EN
    ,
    output logic [15:0]                   total5,
    output logic [15:0]                   total10
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [AW:0]   FULL_LVL   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [4:0]    PRICE_L    = 5'(PRICE_UNITS);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(IDLE_TIMEOUT);

    logic ev5;
    logic ev10;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb5 (
        .clk        (clk),
        .rst        (rst),
        .raw        (coin5_raw),
        .coin_event (ev5)
    );

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb10 (
        .clk        (clk),
        .rst        (rst),
        .raw        (coin10_raw),
        .coin_event (ev10)
    );

    acc_state_e    state;
    acc_state_e    next_state;
    logic [1:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   level;
    logic          full;
    logic          empty;
    logic [3:0]    sum;
    logic [TW-1:0] timer;

    logic          accept;
    logic          reject;
    logic          go_burst;
    logic          pop;
    logic          burst_done;
    logic [1:0]    push_code;
    logic [1:0]    push_units;

    assign level      = wr_ptr - rd_ptr;
    assign full       = (level == FULL_LVL);
    assign empty      = (level == '0);
    assign fifo_level = level;
    assign state_dbg  = state;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (accept)     next_state = COLLECT;
            COLLECT: if (go_burst)   next_state = BURST;
            BURST:   if (burst_done) next_state = IDLE;
            default:                 next_state = IDLE;
        endcase
    end

    // Control decode. The first pop happens on the edge that enters BURST,
    // so the burst follows the trigger without an idle cycle in between.
    always_comb begin
        accept     = 1'b0;
        reject     = 1'b0;
        go_burst   = 1'b0;
        pop        = 1'b0;
        burst_done = 1'b0;
        push_code  = COIN_5;
        push_units = 2'd1;
        if (ev5 || ev10) begin
            if ((ev5 && ev10) || full || (state == BURST)) begin
                reject = 1'b1;
            end else begin
                accept = 1'b1;
            end
        end
        if (ev10) begin
            push_code  = COIN_10;
            push_units = 2'd2;
        end
        if (state == COLLECT) begin
            go_burst = ({1'b0, sum} >= PRICE_L) || full || ((timer <= TW'(1)) && !accept);
        end
        pop        = ((state == BURST) || go_burst) && !empty;
        burst_done = (state == BURST) && empty;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr[AW-1:0]] <= push_code;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            sum          <= 4'd0;
            timer        <= '0;
            coin_code    <= COIN_NONE;
            burst_active <= 1'b0;
            coin_reject  <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            coin_code    <= pop ? mem[rd_ptr[AW-1:0]] : COIN_NONE;
            burst_active <= pop;
            coin_reject  <= reject;

            if (burst_done) begin
                sum <= 4'd0;
            end else if (accept) begin
                sum <= sat_add4(sum, push_units);
            end

            if (accept) begin
                timer <= TIMER_LOAD;
            end else if (state != COLLECT) begin
                timer <= '0;
            end else if (timer != '0) begin
                timer <= timer - 1'b1;
            end
        end
    end

`ifdef COIN_ACCEPTOR_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            total5  <= 16'd0;
            total10 <= 16'd0;
        end else if (accept) begin
            if (ev10) begin
                total10 <= sat_inc16(total10);
            end else begin
                total5 <= sat_inc16(total5);
            end
        end
    end
`endif

endmodule
